// File: rtl/instr_mem_axi_pkg.sv
// Shared types and helpers for the multi-port AXI4-Lite instruction memory.
package instr_mem_axi_pkg;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

  // Byte address to word index; only 32- and 64-bit words are legal.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int data_width);
    return (data_width == 64) ? (addr >> 3) : (addr >> 2);
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Multi-read, single-write, byte-enabled storage with registered read-first outputs.
module instr_mem_array
  import instr_mem_axi_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 3,
  parameter     INIT_FILE  = "",
  localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NB        = DATA_WIDTH / 8
) (
  input  logic                         i_clk,
  input  logic                         i_we,
  input  logic [IW-1:0]                i_waddr,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  input  logic [NB-1:0]                i_wstrb,
  input  logic [NUM_RD-1:0]            i_re,
  input  logic [NUM_RD*IW-1:0]         i_raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata [NUM_RD];

  // Reads and the write share one edge, so a read of the word being written sees old data.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    for (int i = 0; i < NUM_RD; i++) begin
      if (i_re[i]) r_rdata[i] <= r_mem[i_raddr[i*IW +: IW]];
    end
  end

  generate
    for (genvar g = 0; g < NUM_RD; g++) begin : g_out
      assign o_rdata[g*DATA_WIDTH +: DATA_WIDTH] = r_rdata[g];
    end
  endgenerate

endmodule

// File: rtl/instr_mem_axi_mp.sv
// AXI4-Lite loadable instruction memory with NUM_FETCH parallel single-cycle fetch ports.
// Handshakes: a transfer happens on any clock edge where valid and ready are both high.
module instr_mem_axi_mp
  import instr_mem_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 1024,
  parameter int NUM_FETCH  = 2,
  parameter     INIT_FILE  = ""
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [ADDR_WIDTH-1:0]           s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]           s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]         s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]           s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [DATA_WIDTH-1:0]           s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic [NUM_FETCH-1:0]            fetch_en,
  input  logic [NUM_FETCH*ADDR_WIDTH-1:0] fetch_addr,
  output logic [NUM_FETCH*DATA_WIDTH-1:0] fetch_data,
  output logic [NUM_FETCH-1:0]            fetch_valid,
  output logic [NUM_FETCH-1:0]            fetch_err,
  output logic [1:0]                      o_dbg_wr_state,
  output logic                            o_dbg_rd_state
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NUM_RD = NUM_FETCH + 1;

  wr_state_t               r_wr_state;
  rd_state_t               r_rd_state;
  logic                    r_awready, r_wready, r_aw_held, r_w_held, r_bvalid;
  resp_t                   r_bresp;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [NB-1:0]           r_wstrb;
  logic                    r_arready, r_rvalid, r_rzero;
  resp_t                   r_rresp;
  logic [NUM_FETCH-1:0]    r_fvalid, r_ferr, r_fzero;

  logic                    w_aw_hs, w_w_hs, w_aw_have, w_w_have, w_ar_hs;
  logic [31:0]             w_wr_idx, w_rd_idx;
  logic                    w_wr_ok, w_rd_ok, w_we;
  logic [NUM_FETCH-1:0]    w_f_ok;
  logic [NUM_RD*IW-1:0]    w_raddr;
  logic [NUM_RD*DATA_WIDTH-1:0] w_rdata;
  logic                    w_unused;

  assign w_unused  = ^{s00_axi_awprot, s00_axi_arprot};

  assign w_aw_hs   = s00_axi_awvalid & r_awready;
  assign w_w_hs    = s00_axi_wvalid & r_wready;
  assign w_aw_have = r_aw_held | w_aw_hs;
  assign w_w_have  = r_w_held | w_w_hs;
  assign w_ar_hs   = s00_axi_arvalid & r_arready;

  assign w_wr_idx  = word_index(32'(r_awaddr), DATA_WIDTH);
  assign w_rd_idx  = word_index(32'(s00_axi_araddr), DATA_WIDTH);
  assign w_wr_ok   = w_wr_idx < 32'(DEPTH);
  assign w_rd_ok   = w_rd_idx < 32'(DEPTH);
  assign w_we      = (r_wr_state == W_EXEC) && w_wr_ok;

  assign w_raddr[IW-1:0] = w_rd_idx[IW-1:0];

  generate
    for (genvar g = 0; g < NUM_FETCH; g++) begin : g_fetch
      logic [31:0] w_f_idx;
      assign w_f_idx = word_index(32'(fetch_addr[g*ADDR_WIDTH +: ADDR_WIDTH]), DATA_WIDTH);
      assign w_f_ok[g] = w_f_idx < 32'(DEPTH);
      assign w_raddr[(g+1)*IW +: IW] = w_f_idx[IW-1:0];
      assign fetch_data[g*DATA_WIDTH +: DATA_WIDTH] =
        r_fzero[g] ? '0 : w_rdata[(g+1)*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  instr_mem_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_RD     (NUM_RD),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .i_clk   (s00_axi_aclk),
    .i_we    (w_we),
    .i_waddr (w_wr_idx[IW-1:0]),
    .i_wdata (r_wdata),
    .i_wstrb (r_wstrb),
    .i_re    ({fetch_en, w_ar_hs}),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_wr_state <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awaddr  <= s00_axi_awaddr;
            r_aw_held <= 1'b1;
          end
          if (w_w_hs) begin
            r_wdata  <= s00_axi_wdata;
            r_wstrb  <= s00_axi_wstrb;
            r_w_held <= 1'b1;
          end
          r_awready <= !w_aw_have;
          r_wready  <= !w_w_have;
          if (w_aw_have && w_w_have) r_wr_state <= W_EXEC;
        end
        W_EXEC: begin
          r_bresp    <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
          r_bvalid   <= 1'b1;
          r_aw_held  <= 1'b0;
          r_w_held   <= 1'b0;
          r_wr_state <= W_RESP;
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // rdata itself lives in the array's port-0 register; r_rzero masks out-of-range and reset.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_rd_state <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rzero    <= 1'b1;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          r_arready <= !w_ar_hs;
          if (w_ar_hs) begin
            r_rzero    <= !w_rd_ok;
            r_rresp    <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            r_rvalid   <= 1'b1;
            r_rd_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (s00_axi_rready) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_state <= R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_fvalid <= '0;
      r_ferr   <= '0;
      r_fzero  <= '1;
    end else begin
      r_fvalid <= fetch_en;
      r_ferr   <= fetch_en & ~w_f_ok;
      r_fzero  <= (fetch_en & ~w_f_ok) | (~fetch_en & r_fzero);
    end
  end

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_wready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = r_bresp;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rresp   = r_rresp;
  assign s00_axi_rdata   = r_rzero ? '0 : w_rdata[DATA_WIDTH-1:0];
  assign fetch_valid     = r_fvalid;
  assign fetch_err       = r_ferr;
  assign o_dbg_wr_state  = r_wr_state;
  assign o_dbg_rd_state  = r_rd_state;

endmodule

// File: tb/tb_instr_mem_axi_mp.sv
// Directed bench for instr_mem_axi_mp: AXI load/readback, strobes, collisions, range errors, reset.
module tb_instr_mem_axi_mp;

  logic        clk = 1'b0;
  logic        areset;
  logic [12:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  fetch_en, fetch_valid, fetch_err;
  logic [25:0] fetch_addr;
  logic [63:0] fetch_data;
  logic [1:0]  dbg_wr_state;
  logic        dbg_rd_state;

  int n_checks = 0;
  int n_err    = 0;

  logic [1:0]  resp;
  logic [31:0] rd;
  logic        stable;

  always #5 clk = ~clk;

  instr_mem_axi_mp #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (13),
    .DEPTH      (1024),
    .NUM_FETCH  (2)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (areset),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .fetch_en        (fetch_en),
    .fetch_addr      (fetch_addr),
    .fetch_data      (fetch_data),
    .fetch_valid     (fetch_valid),
    .fetch_err       (fetch_err),
    .o_dbg_wr_state  (dbg_wr_state),
    .o_dbg_rd_state  (dbg_rd_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
    logic aw_done, w_done;
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready) w_done = 1'b1;
      step();
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
      n++;
    end
    check("write_handshakes", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!bvalid && n < 20) begin
      step();
      n++;
    end
    check("bvalid_seen", bvalid, 1'b1);
    r = bresp;
    step();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [12:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1; n = 0;
    while (!arready && n < 20) begin
      step();
      n++;
    end
    check("arready_seen", arready, 1'b1);
    step();
    arvalid = 1'b0;
    check("rvalid_after_ar", rvalid, 1'b1);
    d = rdata;
    r = rresp;
    step();
    rready = 1'b0;
  endtask

  task automatic split_write(input logic aw_first, input logic [12:0] a, input logic [31:0] d);
    awaddr = a; wdata = d; wstrb = 4'hF;
    if (aw_first) awvalid = 1'b1; else wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    step();
    check("split_latched_ready_low", aw_first ? awready : wready, 1'b0);
    check("split_other_ready_high", aw_first ? wready : awready, 1'b1);
    check("split_no_early_b", bvalid, 1'b0);
    if (aw_first) wvalid = 1'b1; else awvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("split_exec_no_b", bvalid, 1'b0);
    step();
    check("split_bvalid", bvalid, 1'b1);
    check("split_bresp", bresp, 2'b00);
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("split_b_done", bvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    awaddr = '0; araddr = '0; awprot = 3'b000; arprot = 3'b000;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0; fetch_en = '0; fetch_addr = '0;

    // Reset state
    repeat (3) step();
    check("reset_ctrl", {awready, wready, arready, bvalid, rvalid, fetch_valid, fetch_err}, '0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_fetch_data", fetch_data, 64'h0);
    areset = 1'b0;
    step();
    check("readies_after_reset", {awready, wready, arready}, 3'b111);

    // Basic load and readback
    for (int i = 0; i < 4; i++) begin
      axi_write(13'(i * 4), 32'(i + 1), 4'hF, resp);
      check("basic_bresp", resp, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(13'(i * 4), rd, resp);
      check("basic_rdata", rd, 32'(i + 1));
      check("basic_rresp", resp, 2'b00);
    end

    // Fetch packing, back-to-back fetches, hold when idle
    fetch_addr = {13'h00C, 13'h000}; fetch_en = 2'b11;
    step();
    check("fetch_valid_both", fetch_valid, 2'b11);
    check("fetch_data_pack", fetch_data, {32'h4, 32'h1});
    fetch_addr = {13'h004, 13'h008};
    step();
    check("fetch_b2b_1", fetch_data, {32'h2, 32'h3});
    fetch_addr = {13'h008, 13'h004}; fetch_en = 2'b01;
    step();
    check("fetch_b2b_2_valid", fetch_valid, 2'b01);
    check("fetch_b2b_2_data", fetch_data, {32'h2, 32'h2});
    fetch_en = 2'b00;
    step();
    check("fetch_idle_valid", fetch_valid, 2'b00);
    check("fetch_idle_hold", fetch_data, {32'h2, 32'h2});

    // Split AW/W ordering
    split_write(1'b1, 13'h010, 32'hDEADBEEF);
    axi_read(13'h010, rd, resp);
    check("aw_first_readback", rd, 32'hDEADBEEF);
    split_write(1'b0, 13'h014, 32'hCAFEF00D);
    axi_read(13'h014, rd, resp);
    check("w_first_readback", rd, 32'hCAFEF00D);

    // Byte strobes and empty strobe
    axi_write(13'h018, 32'hFFFFFFFF, 4'hF, resp);
    axi_write(13'h018, 32'h000000AA, 4'b0001, resp);
    axi_read(13'h018, rd, resp);
    check("strobe_byte0", rd, 32'hFFFFFFAA);
    axi_write(13'h018, 32'h12345678, 4'b0000, resp);
    check("strobe_zero_bresp", resp, 2'b00);
    axi_read(13'h018, rd, resp);
    check("strobe_zero_unchanged", rd, 32'hFFFFFFAA);

    // Read-first collision: fetches and an AXI read land on the W_EXEC cycle
    axi_write(13'h020, 32'h11111111, 4'hF, resp);
    awaddr = 13'h020; wdata = 32'h22222222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("collision_exec_state", dbg_wr_state, 2'd1);
    fetch_addr = {13'h020, 13'h020}; fetch_en = 2'b11;
    araddr = 13'h020; arvalid = 1'b1;
    step();
    fetch_en = 2'b00; arvalid = 1'b0;
    check("collision_fetch_old", fetch_data, {32'h11111111, 32'h11111111});
    check("collision_fetch_valid", fetch_valid, 2'b11);
    check("collision_axi_old", rdata, 32'h11111111);
    check("collision_bvalid", bvalid, 1'b1);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    fetch_en = 2'b11;
    step();
    fetch_en = 2'b00;
    check("collision_fetch_new", fetch_data, {32'h22222222, 32'h22222222});

    // Out-of-range accesses
    axi_write(13'h1000, 32'h55555555, 4'hF, resp);
    check("oor_bresp", resp, 2'b10);
    axi_read(13'h1000, rd, resp);
    check("oor_rdata", rd, 32'h0);
    check("oor_rresp", resp, 2'b10);
    axi_read(13'h000, rd, resp);
    check("oor_no_alias_write", rd, 32'h1);
    fetch_addr = {13'h1000, 13'h004}; fetch_en = 2'b11;
    step();
    fetch_en = 2'b00;
    check("oor_fetch_err", fetch_err, 2'b10);
    check("oor_fetch_data", fetch_data, {32'h0, 32'h2});
    step();
    check("oor_fetch_err_oneshot", {fetch_valid, fetch_err}, 4'b0000);
    check("oor_fetch_hold_zero", fetch_data, {32'h0, 32'h2});

    // Hold B and R pending, then reset in W_RESP
    awaddr = 13'h024; wdata = 32'h0BADF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; araddr = 13'h000; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    step();
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(bvalid && rvalid && rdata == 32'h1 && bresp == 2'b00 && !awready && !arready))
        stable = 1'b0;
      step();
    end
    check("pending_stable", stable, 1'b1);
    check("pending_wr_state", dbg_wr_state, 2'd2);
    areset = 1'b1;
    step();
    check("midreset_clear", {awready, wready, arready, bvalid, rvalid}, 5'b00000);
    areset = 1'b0;
    step();
    check("midreset_readies", {awready, wready, arready}, 3'b111);

    // A lone AW captured before reset must be discarded
    awaddr = 13'h000; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    areset = 1'b1;
    step();
    areset = 1'b0;
    step();
    wdata = 32'hBAD0BAD0; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    step();
    step();
    check("discard_no_b", bvalid, 1'b0);
    awaddr = 13'h028; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    step();
    check("discard_b_after_aw", bvalid, 1'b1);
    bready = 1'b1;
    step();
    bready = 1'b0;
    axi_read(13'h000, rd, resp);
    check("discard_word0_intact", rd, 32'h1);
    axi_read(13'h028, rd, resp);
    check("discard_new_aw_used", rd, 32'hBAD0BAD0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
